// File: rtl/instr_encoder_if.sv
// Field-set handshake between a program source and instr_encoder.
// The master drives one decoded MIPS field set per cycle; the slave answers with in_ready.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] imm26;

  modport master (
    output in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm16, imm26,
    input  in_ready
  );

  modport slave (
    input  in_valid, fmt, opcode, rs, rt, rd, shamt, funct, imm16, imm26,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs R/I/J field sets into 32-bit MIPS words and streams them into IM at consecutive addresses.
// Define INSTR_ENC_FIELD_CHECK_EN to reject field sets carrying nonzero fields unused by their format.
module instr_encoder #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  instr_encoder_if.slave    in_if,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  localparam logic [ADDR_W:0] DepthCount = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;

  logic        ready;
  logic        accept;
  logic        legal;
  logic [31:0] packed_word;
  logic [ADDR_W:0] count_inc;

  assign ready          = !reset && !clear && (state_q == ST_LOAD);
  assign in_if.in_ready = ready;
  assign accept         = in_if.in_valid && ready;
  assign count_inc      = count_q + 1'b1;

  always_comb begin
    packed_word = '0;
    case (in_if.fmt)
      2'd0:    packed_word = {in_if.opcode, in_if.rs, in_if.rt, in_if.rd, in_if.shamt, in_if.funct};
      2'd1:    packed_word = {in_if.opcode, in_if.rs, in_if.rt, in_if.imm16};
      2'd2:    packed_word = {in_if.opcode, in_if.imm26};
      default: packed_word = '0;
    endcase
  end

`ifdef INSTR_ENC_FIELD_CHECK_EN
  logic stray;

  // A field set is only trusted when every field its format ignores is zero.
  always_comb begin
    stray = 1'b0;
    case (in_if.fmt)
      2'd0:    stray = (|in_if.imm16) || (|in_if.imm26);
      2'd1:    stray = (|in_if.rd) || (|in_if.shamt) || (|in_if.funct) || (|in_if.imm26);
      2'd2:    stray = (|in_if.rs) || (|in_if.rt) || (|in_if.rd) || (|in_if.shamt)
                       || (|in_if.funct) || (|in_if.imm16);
      default: stray = 1'b0;
    endcase
  end

  assign legal = (in_if.fmt != 2'd3) && !stray;
`else
  assign legal = (in_if.fmt != 2'd3);
`endif

  // Address and data hold between writes; only the strobe and err are pulses.
  always_comb begin
    state_d    = state_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    count_d    = count_q;
    err_d      = 1'b0;
    if (clear) begin
      count_d = '0;
      state_d = ST_LOAD;
    end else if (accept) begin
      if (legal) begin
        im_we_d    = 1'b1;
        im_addr_d  = count_q[ADDR_W-1:0];
        im_wdata_d = packed_word;
        count_d    = count_inc;
        if (count_inc == DepthCount) begin
          state_d = ST_FULL;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign count    = count_q;
  assign full     = (count_q == DepthCount);
  assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder with a 4-word IM so the full/clear path is reachable.
// Honours INSTR_ENC_FIELD_CHECK_EN the same way the design does.
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] imm26;
  } fields_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [ADDR_W:0]   cnt;
    logic              full;
    logic              err;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  instr_encoder_if enc_if ();

  instr_encoder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_if    (enc_if),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .count    (count),
    .full     (full),
    .err      (err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       m_data = '0;
  logic [ADDR_W:0]   m_count = '0;
  logic              m_err = 1'b0;
  logic              m_load = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] packModel(input logic [1:0] f, input fields_t fs);
    case (f)
      2'd0:    return (32'(fs.opcode) << 26) | (32'(fs.rs) << 21) | (32'(fs.rt) << 16)
                      | (32'(fs.rd) << 11) | (32'(fs.shamt) << 6) | 32'(fs.funct);
      2'd1:    return (32'(fs.opcode) << 26) | (32'(fs.rs) << 21) | (32'(fs.rt) << 16) | 32'(fs.imm16);
      2'd2:    return (32'(fs.opcode) << 26) | 32'(fs.imm26);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic legalModel(input logic [1:0] f, input fields_t fs);
    if (f == 2'd3) return 1'b0;
`ifdef INSTR_ENC_FIELD_CHECK_EN
    case (f)
      2'd0:    return (fs.imm16 == 0) && (fs.imm26 == 0);
      2'd1:    return (fs.rd == 0) && (fs.shamt == 0) && (fs.funct == 0) && (fs.imm26 == 0);
      default: return (fs.rs == 0) && (fs.rt == 0) && (fs.rd == 0) && (fs.shamt == 0)
                      && (fs.funct == 0) && (fs.imm16 == 0);
    endcase
`else
    return 1'b1;
`endif
  endfunction

  function automatic fields_t cleanFields(input logic [1:0] f, input fields_t fs);
    fields_t c;
    c = '0;
    c.opcode = fs.opcode;
    if (f == 2'd0) begin
      c.rs = fs.rs; c.rt = fs.rt; c.rd = fs.rd; c.shamt = fs.shamt; c.funct = fs.funct;
    end else if (f == 2'd1) begin
      c.rs = fs.rs; c.rt = fs.rt; c.imm16 = fs.imm16;
    end else if (f == 2'd2) begin
      c.imm26 = fs.imm26;
    end
    return c;
  endfunction

  function automatic fields_t randFields();
    fields_t r;
    r.opcode = 6'($urandom);  r.rs = 5'($urandom);     r.rt = 5'($urandom);
    r.rd = 5'($urandom);      r.shamt = 5'($urandom);  r.funct = 6'($urandom);
    r.imm16 = 16'($urandom);  r.imm26 = 26'($urandom);
    return r;
  endfunction

  // Drives one cycle of inputs just after a rising edge, predicts the next edge, then compares.
  task automatic applyStimulus(input logic rst, input logic clr, input logic vld,
                               input logic [1:0] f, input fields_t fs);
    exp_t e;
    logic rdy, acc;
    reset           = rst;
    clear           = clr;
    enc_if.in_valid = vld;
    enc_if.fmt      = f;
    enc_if.opcode   = fs.opcode;
    enc_if.rs       = fs.rs;
    enc_if.rt       = fs.rt;
    enc_if.rd       = fs.rd;
    enc_if.shamt    = fs.shamt;
    enc_if.funct    = fs.funct;
    enc_if.imm16    = fs.imm16;
    enc_if.imm26    = fs.imm26;
    rdy = !rst && !clr && m_load;
    #1;
    checkOutput("in_ready", enc_if.in_ready, rdy);
    acc = vld && rdy;
    if (rst) begin
      m_we = 0; m_addr = '0; m_data = '0; m_count = '0; m_err = 0; m_load = 1;
    end else if (clr) begin
      m_we = 0; m_count = '0; m_err = 0; m_load = 1;
    end else if (acc && legalModel(f, fs)) begin
      m_we = 1; m_err = 0;
      m_addr = m_count[ADDR_W-1:0];
      m_data = packModel(f, fs);
      m_count = m_count + 1'b1;
      if (m_count == DEPTH) m_load = 0;
    end else begin
      m_we = 0; m_err = acc;
    end
    e.we = m_we; e.addr = m_addr; e.data = m_data; e.cnt = m_count;
    e.full = (m_count == DEPTH); e.err = m_err;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      checkOutput("im_we", im_we, e.we);
      checkOutput("im_addr", im_addr, e.addr);
      checkOutput("im_wdata", im_wdata, e.data);
      checkOutput("count", count, e.cnt);
      checkOutput("full", full, e.full);
      checkOutput("err", err, e.err);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0);
  endtask

  task automatic doClear();
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, '0);
  endtask

  initial begin
    fields_t fs;
    logic [1:0] f;
    int writes;

    enc_if.in_valid = 1'b0;
    enc_if.fmt = '0; enc_if.opcode = '0; enc_if.rs = '0; enc_if.rt = '0; enc_if.rd = '0;
    enc_if.shamt = '0; enc_if.funct = '0; enc_if.imm16 = '0; enc_if.imm26 = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, '0);
    checkOutput("reset_count", count, 0);
    idle();

    // R addu $3,$1,$2
    fs = '0; fs.rs = 5'd1; fs.rt = 5'd2; fs.rd = 5'd3; fs.funct = 6'h21;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, fs);
    checkOutput("addu_word", im_wdata, 32'h00221821);
    checkOutput("addu_addr", im_addr, 0);
    checkOutput("addu_count", count, 1);
    doClear();

    // ori then j, back to back
    fs = '0; fs.opcode = 6'h0d; fs.rt = 5'd1; fs.imm16 = 16'h1234;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, fs);
    checkOutput("ori_word", im_wdata, 32'h34011234);
    fs = '0; fs.opcode = 6'h02; fs.imm26 = 26'h100;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, fs);
    checkOutput("j_word", im_wdata, 32'h08000100);
    checkOutput("j_addr", im_addr, 1);
    checkOutput("j_we_no_bubble", im_we, 1);
    idle();
    doClear();

    // illegal format: consumed, err pulse, address unchanged for next word
    fs = randFields();
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, fs);
    checkOutput("illegal_err", err, 1);
    checkOutput("illegal_we", im_we, 0);
    fs = '0; fs.opcode = 6'h0d; fs.imm16 = 16'hbeef;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, fs);
    checkOutput("after_illegal_addr", im_addr, 0);
    checkOutput("after_illegal_err", err, 0);
    idle();
    doClear();

    // lw $8,4($29) with a stray rd
    fs = '0; fs.opcode = 6'h23; fs.rs = 5'd29; fs.rt = 5'd8; fs.imm16 = 16'd4; fs.rd = 5'd5;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, fs);
`ifdef INSTR_ENC_FIELD_CHECK_EN
    checkOutput("lw_stray_err", err, 1);
    checkOutput("lw_stray_we", im_we, 0);
`else
    checkOutput("lw_stray_word", im_wdata, 32'h8FA80004);
    checkOutput("lw_stray_we", im_we, 1);
`endif
    doClear();

    // hold in_valid for six cycles into a four-word IM
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      f = 2'($urandom_range(0, 2));
      applyStimulus(1'b0, 1'b0, 1'b1, f, cleanFields(f, randFields()));
      if (im_we === 1'b1) writes++;
    end
    checkOutput("fill_writes", writes, DEPTH);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_ready", enc_if.in_ready, 0);
    doClear();
    checkOutput("clear_count", count, 0);
    fs = '0; fs.opcode = 6'h02; fs.imm26 = 26'h3;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, fs);
    checkOutput("post_clear_addr", im_addr, 0);

    // reset the cycle after an accept
    fs = '0; fs.opcode = 6'h0d; fs.imm16 = 16'h7;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, fs);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, fs);
    checkOutput("reset_we", im_we, 0);
    checkOutput("reset_count2", count, 0);
    idle();

    // random mix with occasional clears
    for (int i = 0; i < 60; i++) begin
      f = 2'($urandom_range(0, 3));
      fs = randFields();
      if ($urandom_range(0, 1) == 0) fs = cleanFields(f, fs);
      applyStimulus(1'b0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), f, fs);
    end
    idle();

    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
